// File: rtl/resource_arbiter_mon.sv
// rtl/resource_arbiter_mon.sv - round-robin resource granter with per-channel protocol monitors
//
// Build option: define ARB_TIMEOUT_EN to bound ownership to MAX_HOLD BUSY cycles
// (forced revoke plus owner monitor fail). Undefined: ownership is unbounded.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   req          in   [N]     per-channel request, held until granted
//   chan_use     in   [N]     per-channel resource-in-use indicator
//   chan_release in   [N]     per-channel release pulse
//   fail_clr     in   synchronous clear of all sticky fail flags
//   grant        out  [N]     one-hot grant, held while the channel owns the resource
//   busy         out  resource owned
//   owner        out  [IDX_W] index of the current or last owner
//   fail         out  [N]     sticky per-channel protocol violation
//   fail_any     out  OR of fail
// The use/release channels carry a chan_ prefix because "use" and "release"
// are reserved words in SystemVerilog.

module resource_arbiter_mon #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     chan_use,
  input  logic [N-1:0]     chan_release,
  input  logic             fail_clr,
  output logic [N-1:0]     grant,
  output logic             busy,
  output logic [IDX_W-1:0] owner,
  output logic [N-1:0]     fail,
  output logic             fail_any
);

  if (N < 2 || N > 16 || (1 << IDX_W) < N || MAX_HOLD < 1) begin : g_param_check
    $error("resource_arbiter_mon: illegal parameter combination");
  end

  typedef enum logic {A_IDLE, A_BUSY} arb_state_t;
  typedef enum logic [2:0] {M_IDLE, M_WAIT, M_GAP, M_USE, M_FAIL} mon_state_t;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             any_req;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] cand;
  logic             owner_rel;

  mon_state_t       mon_q [N];
  mon_state_t       mon_d [N];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             revoke;
`endif

  // Round-robin pick: scan from ptr+1 and wrap, ending on ptr itself so a
  // lone requester that just released can win again.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % N);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        sel     = cand;
      end
    end
  end

  assign owner_rel = chan_release[owner_q];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
    revoke  = 1'b0;
`endif
    case (state_q)
      A_IDLE: begin
        if (any_req) begin
          state_d = A_BUSY;
          owner_d = sel;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      A_BUSY: begin
        if (owner_rel) begin
          state_d = A_IDLE;
          ptr_d   = owner_q;
        end
`ifdef ARB_TIMEOUT_EN
        // Revoke on the edge where the counter would reach MAX_HOLD.
        else if (hold_q == CNT_W'(MAX_HOLD - 1)) begin
          revoke  = 1'b1;
          state_d = A_IDLE;
          ptr_d   = owner_q;
        end else begin
          hold_d  = hold_q + 1'b1;
        end
`endif
      end
      default: state_d = A_IDLE;
    endcase
  end

  assign busy  = (state_q == A_BUSY);
  assign owner = owner_q;
  assign grant = busy ? (N'(1) << owner_q) : '0;

  // Monitors observe the registered grant; they never feed back into the arbiter.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      mon_d[i] = mon_q[i];
      case (mon_q[i])
        M_IDLE: begin
          if (req[i] && grant[i])       mon_d[i] = M_GAP;
          else if (req[i])              mon_d[i] = M_WAIT;
        end
        M_WAIT: begin
          if (grant[i])                 mon_d[i] = M_GAP;
          else if (!req[i])             mon_d[i] = M_FAIL;
        end
        // One unchecked cycle mirrors the requester's post-grant state.
        M_GAP:                          mon_d[i] = M_USE;
        M_USE: begin
          if (chan_release[i])          mon_d[i] = M_IDLE;
          else if (!chan_use[i])        mon_d[i] = M_FAIL;
        end
        M_FAIL:                         mon_d[i] = M_FAIL;
        default:                        mon_d[i] = M_IDLE;
      endcase
`ifdef ARB_TIMEOUT_EN
      if (revoke && owner_q == IDX_W'(i)) mon_d[i] = M_FAIL;
`endif
      if (fail_clr) mon_d[i] = M_IDLE;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      fail[i] = (mon_q[i] == M_FAIL);
    end
  end

  assign fail_any = |fail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= A_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
      for (int i = 0; i < N; i++) begin
        mon_q[i] <= M_IDLE;
      end
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
      for (int i = 0; i < N; i++) begin
        mon_q[i] <= mon_d[i];
      end
    end
  end

endmodule

// File: tb/tb_resource_arbiter_mon.sv
// tb/tb_resource_arbiter_mon.sv - directed self-checking bench for resource_arbiter_mon

module tb_resource_arbiter_mon;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] chan_use;
  logic [3:0] chan_release;
  logic       fail_clr;
  logic [3:0] grant;
  logic       busy;
  logic [1:0] owner;
  logic [3:0] fail;
  logic       fail_any;

  int n_checks = 0;
  int n_fails  = 0;

  resource_arbiter_mon #(.N(4), .IDX_W(2), .MAX_HOLD(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .chan_use     (chan_use),
    .chan_release (chan_release),
    .fail_clr     (fail_clr),
    .grant        (grant),
    .busy         (busy),
    .owner        (owner),
    .fail         (fail),
    .fail_any     (fail_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset        = 1'b1;
    req          = '0;
    chan_use     = '0;
    chan_release = '0;
    fail_clr     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0000) begin n_fails++; $display("FAIL reset_grant: got %b want %b", grant, 4'b0000); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (owner !== 2'd0) begin n_fails++; $display("FAIL reset_owner: got %0d want 0", owner); end
    n_checks++; if (fail !== 4'b0000) begin n_fails++; $display("FAIL reset_fail: got %b want 0000", fail); end
    n_checks++; if (fail_any !== 1'b0) begin n_fails++; $display("FAIL reset_fail_any: got %b want 0", fail_any); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_grant();
    do_reset();
    req = 4'b0001;
    @(negedge clk); // t1
    n_checks++; if (grant !== 4'b0001) begin n_fails++; $display("FAIL t1_grant: got %b want 0001", grant); end
    n_checks++; if (owner !== 2'd0) begin n_fails++; $display("FAIL t1_owner: got %0d want 0", owner); end
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL t1_busy: got %b want 1", busy); end
    req = 4'b0000;
    @(negedge clk); // t2
    chan_release = 4'b1000;
    @(negedge clk); // t3
    n_checks++; if (busy !== 1'b1 || grant !== 4'b0001) begin n_fails++; $display("FAIL t1_foreign_release: busy %b grant %b want 1 0001", busy, grant); end
    chan_release = 4'b0000;
    chan_use     = 4'b0001;
    @(negedge clk); // t4
    @(negedge clk); // t5
    chan_release = 4'b0001;
    @(negedge clk); // t6
    n_checks++; if (grant !== 4'b0000) begin n_fails++; $display("FAIL t1_release_grant: got %b want 0000", grant); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL t1_release_busy: got %b want 0", busy); end
    n_checks++; if (fail !== 4'b0000 || fail_any !== 1'b0) begin n_fails++; $display("FAIL t1_fail: got %b/%b want 0000/0", fail, fail_any); end
    chan_release = 4'b0000;
    chan_use     = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [3:0] seen [$];
    int         gaps [$];
    logic [3:0] exp_order [5];
    logic [3:0] prev;
    logic [3:0] g;
    int         age;
    int         idle_run;
    exp_order = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    do_reset();
    req      = 4'b1111;
    chan_use = 4'b1111;
    prev     = '0;
    age      = 0;
    idle_run = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      g = grant;
      if (g != 4'b0000 && prev == 4'b0000) begin
        seen.push_back(g);
        gaps.push_back(idle_run);
        age = 0;
      end
      if (g == 4'b0000) idle_run++;
      else idle_run = 0;
      if (g != 4'b0000) begin
        chan_release = (age == 3) ? g : 4'b0000;
        age++;
      end else begin
        chan_release = 4'b0000;
      end
      prev = g;
      if (seen.size() == 5) break;
    end
    n_checks++; if (seen.size() != 5) begin n_fails++; $display("FAIL rr_count: got %0d grants want 5", seen.size()); end
    for (int k = 0; k < 5; k++) begin
      if (k < seen.size()) begin
        n_checks++; if (seen[k] !== exp_order[k]) begin n_fails++; $display("FAIL rr_order[%0d]: got %b want %b", k, seen[k], exp_order[k]); end
        if (k > 0) begin
          n_checks++; if (gaps[k] != 1) begin n_fails++; $display("FAIL rr_gap[%0d]: got %0d idle cycles want 1", k, gaps[k]); end
        end
      end
    end
    n_checks++; if (fail !== 4'b0000) begin n_fails++; $display("FAIL rr_fail: got %b want 0000", fail); end
    chan_release = 4'b0000;
  endtask

  task automatic test_drop_before_grant();
    do_reset();
    req = 4'b0001;
    @(negedge clk); // t1
    n_checks++; if (grant !== 4'b0001) begin n_fails++; $display("FAIL t3_owner_grant: got %b want 0001", grant); end
    req      = 4'b0100;
    chan_use = 4'b0001;
    @(negedge clk); // t2: ch2 waiting
    n_checks++; if (fail !== 4'b0000) begin n_fails++; $display("FAIL t3_wait_fail: got %b want 0000", fail); end
    req = 4'b0000;
    @(negedge clk); // t3
    n_checks++; if (fail !== 4'b0100) begin n_fails++; $display("FAIL t3_fail: got %b want 0100", fail); end
    n_checks++; if (fail_any !== 1'b1) begin n_fails++; $display("FAIL t3_fail_any: got %b want 1", fail_any); end
    fail_clr = 1'b1;
    @(negedge clk); // t4
    fail_clr = 1'b0;
    n_checks++; if (fail !== 4'b0000 || fail_any !== 1'b0) begin n_fails++; $display("FAIL t3_clear: got %b/%b want 0000/0", fail, fail_any); end
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL t3_busy_kept: got %b want 1", busy); end
    chan_use = 4'b0000;
  endtask

  task automatic test_use_violation();
    do_reset();
    req = 4'b0001;
    @(negedge clk); // t1
    req = 4'b0000;
    @(negedge clk); // t2
    @(negedge clk); // t3: first M_USE cycle with use=0
    @(negedge clk); // t4
    n_checks++; if (fail !== 4'b0001) begin n_fails++; $display("FAIL t4_fail: got %b want 0001", fail); end
    n_checks++; if (fail_any !== 1'b1) begin n_fails++; $display("FAIL t4_fail_any: got %b want 1", fail_any); end
    n_checks++; if (busy !== 1'b1 || grant !== 4'b0001) begin n_fails++; $display("FAIL t4_still_busy: busy %b grant %b want 1 0001", busy, grant); end
    @(negedge clk); // t5
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL t4_hold: got %b want 1", busy); end
    chan_release = 4'b0001;
    @(negedge clk); // t6
    chan_release = 4'b0000;
    n_checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_fails++; $display("FAIL t4_released: busy %b grant %b want 0 0000", busy, grant); end
    n_checks++; if (fail !== 4'b0001) begin n_fails++; $display("FAIL t4_sticky: got %b want 0001", fail); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0010;
    @(negedge clk); // t1
    n_checks++; if (grant !== 4'b0010 || owner !== 2'd1) begin n_fails++; $display("FAIL t5_grant: grant %b owner %0d want 0010 1", grant, owner); end
    req = 4'b0000;
    repeat (3) @(negedge clk); // t4: ch1 failed on use=0
    n_checks++; if (fail !== 4'b0010) begin n_fails++; $display("FAIL t5_prefail: got %b want 0010", fail); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (grant !== 4'b0000) begin n_fails++; $display("FAIL t5_async_grant: got %b want 0000", grant); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL t5_async_busy: got %b want 0", busy); end
    n_checks++; if (owner !== 2'd0) begin n_fails++; $display("FAIL t5_async_owner: got %0d want 0", owner); end
    n_checks++; if (fail !== 4'b0000 || fail_any !== 1'b0) begin n_fails++; $display("FAIL t5_async_fail: got %b/%b want 0000/0", fail, fail_any); end
    @(negedge clk);
    reset = 1'b0;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int hold;
    do_reset();
    req      = 4'b1001;
    chan_use = 4'b1001;
    @(negedge clk); // t1
    n_checks++; if (grant !== 4'b1000) begin n_fails++; $display("FAIL t6_grant: got %b want 1000", grant); end
    req  = 4'b0001;
    hold = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (grant != 4'b1000) break;
      hold++;
    end
    n_checks++; if (hold != 15) begin n_fails++; $display("FAIL t6_hold: got %0d cycles want 15", hold); end
    n_checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_fails++; $display("FAIL t6_revoke: busy %b grant %b want 0 0000", busy, grant); end
    n_checks++; if (fail !== 4'b1000) begin n_fails++; $display("FAIL t6_fail: got %b want 1000", fail); end
    @(negedge clk);
    n_checks++; if (grant !== 4'b0001) begin n_fails++; $display("FAIL t6_next: got %b want 0001", grant); end
    req      = 4'b0000;
    chan_use = 4'b0000;
  endtask
`endif

  initial begin
    reset        = 1'b1;
    req          = '0;
    chan_use     = '0;
    chan_release = '0;
    fail_clr     = 1'b0;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_drop_before_grant();
    test_use_violation();
    test_async_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
